// File: rtl/poly_arith_pkg.sv
// poly_arith_pkg: shared types and constants for the polynomial arithmetic
// datapath (ML-KEM, N=256).
//   pe_mode_e        : butterfly flavour for pe2 (CT forward / GS inverse)
//   ntt_seq_state_e  : ntt_seq_ctrl FSM states
//   N_COEFF          : coefficients per polynomial
//   NUM_LAYERS       : butterfly layers of the length-256 NTT
package poly_arith_pkg;

  localparam int N_COEFF    = 256;
  localparam int NUM_LAYERS = 7;

  typedef enum logic {
    PE_NTT  = 1'b0,
    PE_INTT = 1'b1
  } pe_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ntt_seq_state_e;

endpackage

// File: rtl/delay_n.sv
// delay_n: N-stage register delay line with asynchronous active-high reset.
//   clk, rst : clock, async reset (clears every stage)
//   d_i      : W-bit input
//   q_o      : d_i delayed by N cycles (N=0 gives a plain wire)
module delay_n #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (N == 0) begin : g_wire
      assign q_o = d_i;
    end else begin : g_pipe
      logic [W-1:0] pipe_q [N];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < N; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= d_i;
          for (int i = 1; i < N; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign q_o = pipe_q[N-1];
    end
  endgenerate

endmodule

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: combinational butterfly address / zeta index generator.
//   layer_i    : layer 0..6
//   b_i        : butterfly index 0..127 within the layer
//   inv_i      : 0 = forward NTT (len = 128>>l), 1 = inverse (len = 2<<l)
//   addr_a_o   : 2*len*group + offset
//   addr_b_o   : addr_a_o + len
//   zeta_idx_o : NTT (1<<l)+group, INTT (128>>l)-1-group
// len is always a power of two, so group/offset are a shift and a mask.
module ntt_addr_gen (
  input  logic [2:0] layer_i,
  input  logic [6:0] b_i,
  input  logic       inv_i,
  output logic [7:0] addr_a_o,
  output logic [7:0] addr_b_o,
  output logic [6:0] zeta_idx_o
);

  logic [2:0] sh;     // log2(len), 1..7
  logic [3:0] sh_p1;  // log2(2*len), 2..8
  logic [7:0] len;
  logic [6:0] off;
  logic [6:0] grp;

  always_comb begin
    sh       = inv_i ? (layer_i + 3'd1) : (3'd7 - layer_i);
    sh_p1    = {1'b0, sh} + 4'd1;
    len      = 8'd1 << sh;
    off      = b_i & 7'(len - 8'd1);
    grp      = b_i >> sh;
    // Bit sh of the group base is always zero, so OR-ing the offset is exact.
    addr_a_o = (8'(grp) << sh_p1) | {1'b0, off};
    addr_b_o = addr_a_o + len;
    // 127>>l == (128>>l)-1; grp never exceeds that, so no underflow.
    zeta_idx_o = inv_i ? ((7'd127 >> layer_i) - grp)
                       : ((7'd1 << layer_i) | grp);
  end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl: sequencer for one pe2 butterfly over a dual-port 256-coeff RAM.
// Runs 7 layers of forward NTT (CT) or inverse NTT (GS); INTT scaling is
// done elsewhere.
//   clk, rst            : clock, async active-high reset
//   start_i, inv_i      : start pulse (accepted in IDLE only), mode latched there
//   busy_o, done_o      : busy from accepted start through the done_o cycle
//   rd_en_o, rd_addr_*  : butterfly read strobe and addresses (j, j+len)
//   zeta_idx_o          : zeta ROM index, aligned with rd_en_o
//   pe_valid_o, pe_mode_o : rd_en_o delayed RD_LAT, with the latched mode
//   wr_en_o, wr_addr_*  : read strobe/addresses delayed RD_LAT+PE_LAT
//   cycle_cnt_o         : only with NTT_SEQ_CTRL_PERF_EN defined; active cycles
//                         of the last transform (clears on start, holds after)
// Handshake: none; start_i is a single-cycle pulse, all strobes are one cycle
// per butterfly and there is no backpressure.
// Each layer is followed by RD_LAT+PE_LAT idle cycles so the next layer never
// reads a coefficient whose write-back is still in flight.
module ntt_seq_ctrl
  import poly_arith_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start_i,
  input  logic     inv_i,
  output logic     busy_o,
  output logic     done_o,
  output logic     rd_en_o,
  output logic [7:0] rd_addr_a_o,
  output logic [7:0] rd_addr_b_o,
  output logic [6:0] zeta_idx_o,
  output pe_mode_e pe_mode_o,
  output logic     pe_valid_o,
  output logic     wr_en_o,
  output logic [7:0] wr_addr_a_o,
  output logic [7:0] wr_addr_b_o
`ifdef NTT_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0] cycle_cnt_o
`endif
);

  localparam int DRAIN_CYC = RD_LAT + PE_LAT;

  ntt_seq_state_e state_q, state_d;
  logic [2:0] layer_q, layer_d;
  logic [6:0] b_q, b_d;
  logic [7:0] drain_q, drain_d;
  logic       inv_q, inv_d;

  logic [7:0] gen_a, gen_b;
  logic [6:0] gen_z;
  logic       pe_mode_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      layer_q <= '0;
      b_q     <= '0;
      drain_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      b_q     <= b_d;
      drain_q <= drain_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    b_d     = b_q;
    drain_d = drain_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ISSUE;
          inv_d   = inv_i;
          layer_d = '0;
          b_d     = '0;
        end
      end
      ISSUE: begin
        b_d = b_q + 7'd1;
        if (b_q == 7'd127) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 8'd1;
        if (drain_q == 8'(DRAIN_CYC - 1)) begin
          if (layer_q < 3'(NUM_LAYERS - 1)) begin
            layer_d = layer_q + 3'd1;
            b_d     = '0;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  ntt_addr_gen u_addr_gen (
    .layer_i    (layer_q),
    .b_i        (b_q),
    .inv_i      (inv_q),
    .addr_a_o   (gen_a),
    .addr_b_o   (gen_b),
    .zeta_idx_o (gen_z)
  );

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign rd_en_o = (state_q == ISSUE);

  // Addresses are forced to zero outside ISSUE so idle outputs stay quiet.
  assign rd_addr_a_o = rd_en_o ? gen_a : '0;
  assign rd_addr_b_o = rd_en_o ? gen_b : '0;
  assign zeta_idx_o  = rd_en_o ? gen_z : '0;

  delay_n #(.W(2), .N(RD_LAT)) u_pe_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({rd_en_o, rd_en_o & inv_q}),
    .q_o ({pe_valid_o, pe_mode_bit})
  );
  assign pe_mode_o = pe_mode_e'(pe_mode_bit);

  delay_n #(.W(17), .N(RD_LAT + PE_LAT)) u_wr_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({rd_en_o, rd_addr_a_o, rd_addr_b_o}),
    .q_o ({wr_en_o, wr_addr_a_o, wr_addr_b_o})
  );

`ifdef NTT_SEQ_CTRL_PERF_EN
  logic [15:0] cyc_q, cyc_d;

  // Counts ISSUE/DRAIN cycles, so it settles at 7*(128+D) and holds.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE && start_i) cyc_d = '0;
    else if (state_q == ISSUE || state_q == DRAIN) cyc_d = cyc_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cycle_cnt_o = cyc_q;
`endif

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// tb_ntt_seq_ctrl: self-checking bench for ntt_seq_ctrl (default parameters).
// Reference: per-cycle expectations derived from layer/butterfly arithmetic;
// write-back addresses go through an expected queue.
module tb_ntt_seq_ctrl;
  import poly_arith_pkg::*;

  localparam int D      = 5;               // RD_LAT + PE_LAT
  localparam int LAYER_C = 128 + D;
  localparam int ACTIVE = 7 * LAYER_C;     // 931

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       inv_i;
  logic       busy_o, done_o, rd_en_o, pe_valid_o, wr_en_o;
  logic [7:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
  logic [6:0] zeta_idx_o;
  pe_mode_e   pe_mode_o;
`ifdef NTT_SEQ_CTRL_PERF_EN
  logic [15:0] cycle_cnt_o;
`endif

  int n_checks;
  int n_errors;
  logic [15:0] exp_q[$];
  int pending [256];

  ntt_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .inv_i       (inv_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .zeta_idx_o  (zeta_idx_o),
    .pe_mode_o   (pe_mode_o),
    .pe_valid_o  (pe_valid_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_a_o (wr_addr_a_o),
    .wr_addr_b_o (wr_addr_b_o)
`ifdef NTT_SEQ_CTRL_PERF_EN
    ,
    .cycle_cnt_o (cycle_cnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Butterfly issued c cycles into the transform (c=1 is the first issue cycle).
  function automatic void model_rd(input bit inv, input int c,
                                   output bit en, output int a, output int b, output int z);
    int l, p, len, g, o;
    en = 0; a = 0; b = 0; z = 0;
    if (c < 1 || c > ACTIVE) return;
    l = (c - 1) / LAYER_C;
    p = (c - 1) % LAYER_C;
    if (p >= 128) return;
    len = inv ? (2 << l) : (128 >> l);
    g   = p / len;
    o   = p % len;
    en  = 1;
    a   = 2 * len * g + o;
    b   = a + len;
    z   = inv ? ((128 >> l) - 1 - g) : ((1 << l) + g);
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"},  busy_o, 0);
    check_val({tag, "_done"},  done_o, 0);
    check_val({tag, "_rd_en"}, rd_en_o, 0);
    check_val({tag, "_rd_a"},  rd_addr_a_o, 0);
    check_val({tag, "_rd_b"},  rd_addr_b_o, 0);
    check_val({tag, "_zeta"},  zeta_idx_o, 0);
    check_val({tag, "_pe_v"},  pe_valid_o, 0);
    check_val({tag, "_pe_m"},  pe_mode_o, 0);
    check_val({tag, "_wr_en"}, wr_en_o, 0);
    check_val({tag, "_wr_a"},  wr_addr_a_o, 0);
    check_val({tag, "_wr_b"},  wr_addr_b_o, 0);
  endtask

  task automatic check_directed(input bit inv, input int c);
    // Fixed points from the address tables.
    if (!inv && c == 1)   begin check_val("ntt_l0_b0_a", rd_addr_a_o, 0);   check_val("ntt_l0_b0_b", rd_addr_b_o, 128); check_val("ntt_l0_b0_z", zeta_idx_o, 1); end
    if (!inv && c == 128) begin check_val("ntt_l0_b127_a", rd_addr_a_o, 127); check_val("ntt_l0_b127_b", rd_addr_b_o, 255); end
    if (!inv && c == 799) begin check_val("ntt_l6_b0_a", rd_addr_a_o, 0);   check_val("ntt_l6_b0_b", rd_addr_b_o, 2);   check_val("ntt_l6_b0_z", zeta_idx_o, 64); end
    if (!inv && c == 800) begin check_val("ntt_l6_b1_a", rd_addr_a_o, 1);   check_val("ntt_l6_b1_b", rd_addr_b_o, 3);   check_val("ntt_l6_b1_z", zeta_idx_o, 64); end
    if (!inv && c == 801) begin check_val("ntt_l6_b2_a", rd_addr_a_o, 4);   check_val("ntt_l6_b2_b", rd_addr_b_o, 6);   check_val("ntt_l6_b2_z", zeta_idx_o, 65); end
    if (!inv && c == 926) begin check_val("ntt_l6_b127_a", rd_addr_a_o, 253); check_val("ntt_l6_b127_b", rd_addr_b_o, 255); check_val("ntt_l6_b127_z", zeta_idx_o, 127); end
    if (inv && c == 1)    begin check_val("intt_l0_b0_a", rd_addr_a_o, 0);  check_val("intt_l0_b0_b", rd_addr_b_o, 2);   check_val("intt_l0_b0_z", zeta_idx_o, 127); end
    if (inv && c == 799)  begin check_val("intt_l6_b0_a", rd_addr_a_o, 0);  check_val("intt_l6_b0_b", rd_addr_b_o, 128); check_val("intt_l6_b0_z", zeta_idx_o, 1); end
  endtask

  // ---------------- driver + scoreboard ----------------
  // glitch_c: cycle at which a stray start_i pulse is driven (0 = none).
  // rst_c   : cycle at which reset is asserted mid-transform (0 = none).
  task automatic run_xform(input bit inv, input int glitch_c, input int rst_c);
    bit en, en_pe, en_wr;
    int a, b, z, ta, tb, tz;
    int done_c;
    logic [15:0] exp_w;
    done_c = -1;
    exp_q.delete();
    for (int i = 0; i < 256; i++) pending[i] = 0;

    start_i = 1'b1;
    inv_i   = inv;
    @(posedge clk); #1;
    start_i = 1'b0;

    for (int c = 1; c <= ACTIVE + 9; c++) begin
      if (c == rst_c) begin
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          check_val("post_rst_wr_en", wr_en_o, 0);
          check_val("post_rst_busy",  busy_o, 0);
        end
        return;
      end

      model_rd(inv, c, en, a, b, z);
      model_rd(inv, c - 1, en_pe, ta, tb, tz);
      model_rd(inv, c - D, en_wr, ta, tb, tz);

      check_val("busy",     busy_o, (c <= ACTIVE + 1));
      check_val("done",     done_o, (c == ACTIVE + 1));
      check_val("rd_en",    rd_en_o, en);
      check_val("pe_valid", pe_valid_o, en_pe);
      check_val("wr_en",    wr_en_o, en_wr);

      if (en) begin
        check_val("rd_a", rd_addr_a_o, a);
        check_val("rd_b", rd_addr_b_o, b);
        check_val("zeta", zeta_idx_o, z);
        exp_q.push_back({8'(a), 8'(b)});
      end
      if (en_pe) check_val("pe_mode", pe_mode_o, inv);

      // No coefficient may be read while its previous write-back is in flight.
      if (rd_en_o) begin
        check_val("raw_a", pending[rd_addr_a_o], 0);
        check_val("raw_b", pending[rd_addr_b_o], 0);
        pending[rd_addr_a_o]++;
        pending[rd_addr_b_o]++;
      end
      if (wr_en_o) begin
        pending[wr_addr_a_o]--;
        pending[wr_addr_b_o]--;
      end

      if (en_wr) begin
        if (exp_q.size() == 0) check_val("wr_q_empty", 1, 0);
        else begin
          exp_w = exp_q.pop_front();
          check_val("wr_a", wr_addr_a_o, exp_w[15:8]);
          check_val("wr_b", wr_addr_b_o, exp_w[7:0]);
        end
      end

      check_directed(inv, c);
      if (done_o && done_c < 0) done_c = c;

      // Stray starts carry the opposite mode; they must change nothing.
      start_i = (c == glitch_c);
      inv_i   = (c == glitch_c) ? ~inv : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start_i = 1'b0;

    // done_c is counted from the acceptance edge; the first issue cycle is 1.
    check_val("start_to_done", done_c - 1, ACTIVE);
    check_val("wr_q_drained", exp_q.size(), 0);
`ifdef NTT_SEQ_CTRL_PERF_EN
    check_val("cycle_cnt", cycle_cnt_o, ACTIVE);
`endif
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(1, 6);
    for (int k = 0; k < n; k++) begin
      inv_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start_i  = 1'b0;
    inv_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle");

    run_xform(1'b0, 300, 0);                       // NTT, stray start at 300
    idle_gap();
    run_xform(1'b1, $urandom_range(2, 900), 0);    // INTT, random stray start
    idle_gap();
    run_xform(1'($urandom_range(0, 1)), ACTIVE + 1, 0); // start in DONE cycle
    idle_gap();
    run_xform(1'($urandom_range(0, 1)), 0, 500);   // reset mid-transform
    run_xform(1'b0, 0, 0);                         // full run after reset
    idle_gap();
    run_xform(1'($urandom_range(0, 1)), $urandom_range(2, 930), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
